// File: rtl/muldiv_sequencer.sv
// Iterative signed multiply/divide engine with its sequencing FSM.
// One shared adder/subtractor, one bit per cycle: shift-add multiply, restoring divide.
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mult_start,
    input  logic             div_start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_is_div;
    logic               r_div_zero;
    logic               r_neg_lo;
    logic               r_neg_hi;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH:0]     r_acc;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH+1:0]   w_sum;
    logic               w_borrow;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_q_fix;
    logic [WIDTH-1:0]   w_r_fix;

    // Magnitudes fit in WIDTH unsigned bits, including |-2^(WIDTH-1)|.
    assign w_abs_a = r_a[WIDTH-1] ? (~r_a + WIDTH'(1)) : r_a;
    assign w_abs_b = r_b[WIDTH-1] ? (~r_b + WIDTH'(1)) : r_b;

    // Shared adder: divide subtracts the divisor from the shifted remainder,
    // multiply conditionally adds the multiplicand to the upper accumulator.
    assign w_shift  = {r_acc[WIDTH-1:0], r_lo[WIDTH-1]};
    assign w_sum    = r_is_div ? ({1'b0, w_shift} - {2'b00, r_b})
                               : ({1'b0, r_acc} + {2'b00, (r_lo[0] ? r_b : WIDTH'(0))});
    assign w_borrow = w_sum[WIDTH+1];

    assign w_prod     = {r_acc[WIDTH-1:0], r_lo};
    assign w_prod_fix = r_neg_lo ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    assign w_q_fix    = r_neg_lo ? (~r_lo + WIDTH'(1)) : r_lo;
    assign w_r_fix    = r_neg_hi ? (~r_acc[WIDTH-1:0] + WIDTH'(1)) : r_acc[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_lo   <= 1'b0;
            r_neg_hi   <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_lo       <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            div_zero   <= 1'b0;
            hi_out     <= '0;
            lo_out     <= '0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (mult_start || div_start) begin
                        r_state  <= S_PREP;
                        busy     <= 1'b1;
                        r_is_div <= ~mult_start;
                        r_a      <= op_a;
                        r_b      <= op_b;
                    end
                end
                S_PREP: begin
                    r_neg_lo   <= r_a[WIDTH-1] ^ r_b[WIDTH-1];
                    r_neg_hi   <= r_a[WIDTH-1];
                    r_lo       <= w_abs_a;
                    r_b        <= w_abs_b;
                    r_acc      <= '0;
                    r_cnt      <= '0;
                    r_div_zero <= r_is_div && (r_b == '0);
                    // Divide-by-zero skips RUN; FIXUP posts its fixed result.
                    r_state    <= (r_is_div && (r_b == '0)) ? S_FIXUP : S_RUN;
                end
                S_RUN: begin
                    if (r_is_div) begin
                        r_acc <= w_borrow ? w_shift : w_sum[WIDTH:0];
                        r_lo  <= {r_lo[WIDTH-2:0], ~w_borrow};
                    end else begin
                        r_acc <= {1'b0, w_sum[WIDTH:1]};
                        r_lo  <= {w_sum[0], r_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_state <= S_FIXUP;
                    end
                end
                S_FIXUP: begin
                    if (r_div_zero) begin
                        hi_out   <= r_a;
                        lo_out   <= '1;
                        div_zero <= 1'b1;
                    end else if (r_is_div) begin
                        hi_out <= w_r_fix;
                        lo_out <= w_q_fix;
                    end else begin
                        hi_out <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo_out <= w_prod_fix[WIDTH-1:0];
                    end
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table plus
// hand-written collision and mid-operation reset sequences.
module tb_muldiv_sequencer;

    logic        clk;
    logic        reset;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_cmp;
    int n_err;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .mult_start (mult_start),
        .div_start  (div_start),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .hi_out     (hi_out),
        .lo_out     (lo_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        d;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Launch one operation at edge E0 and check result, latency, busy span and pulse width.
    task automatic do_op(input string name, input vec_t v);
        int lat;
        int bcnt;
        lat  = -1;
        bcnt = 0;
        @(negedge clk);
        mult_start = v.m;
        div_start  = v.d;
        op_a       = v.a;
        op_b       = v.b;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        if (busy) bcnt++;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        check({name, " latency"}, 32'(lat), 32'(v.lat));
        check({name, " hi"}, hi_out, v.hi);
        check({name, " lo"}, lo_out, v.lo);
        check({name, " div_zero"}, {31'b0, div_zero}, {31'b0, v.dz});
        check({name, " busy_cycles"}, 32'(bcnt), 32'(v.lat + 1));
        @(posedge clk);
        #1;
        check({name, " after_done"}, {29'b0, busy, done, div_zero}, 32'd0);
    endtask

    initial begin
        int lat;
        int extra_done;
        vec_t v;

        n_cmp      = 0;
        n_err      = 0;
        reset      = 1'b1;
        mult_start = 1'b0;
        div_start  = 1'b0;
        op_a       = '0;
        op_b       = '0;

        vecs[0]  = '{1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        vecs[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 34};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        vecs[3]  = '{1'b0, 1'b1, 32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 2};
        vecs[4]  = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 34};
        vecs[5]  = '{1'b1, 1'b1, 32'd3,        32'd4,        32'h00000000, 32'h0000000C, 1'b0, 34};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 34};
        vecs[7]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 34};
        vecs[8]  = '{1'b0, 1'b1, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0, 34};
        vecs[9]  = '{1'b0, 1'b1, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFF2, 1'b0, 34};
        vecs[10] = '{1'b0, 1'b1, 32'd7,        32'hFFFFFF9C, 32'h00000007, 32'h00000000, 1'b0, 34};
        vecs[11] = '{1'b0, 1'b1, 32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 2};
        vecs[12] = '{1'b1, 1'b0, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 1'b0, 34};

        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {27'b0, busy, done, div_zero, 2'b0} | hi_out | lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i]);
        end

        // Collision: div_start mid-RUN and during DONE must both be ignored.
        @(negedge clk);
        mult_start = 1'b1;
        op_a       = 32'd5;
        op_b       = 32'd6;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        lat        = -1;
        for (int k = 1; k <= 60; k++) begin
            if (k == 11) div_start = 1'b1;
            if (k == 12) div_start = 1'b0;
            @(posedge clk);
            #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("collide latency", 32'(lat), 32'd34);
        check("collide lo", lo_out, 32'd30);
        check("collide hi", hi_out, 32'd0);
        div_start = 1'b1;
        op_a      = 32'd9;
        op_b      = 32'd3;
        @(posedge clk);
        #1;
        div_start  = 1'b0;
        extra_done = 0;
        for (int k = 0; k < 40; k++) begin
            if (done || busy) extra_done++;
            @(posedge clk);
            #1;
        end
        check("collide extra_activity", 32'(extra_done), 32'd0);
        check("collide hold_lo", lo_out, 32'd30);

        // Reset during RUN aborts the operation and clears outputs at once.
        @(negedge clk);
        mult_start = 1'b1;
        op_a       = 32'd9;
        op_b       = 32'd9;
        @(posedge clk);
        #1;
        mult_start = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        check("midrun busy_before_reset", {31'b0, busy}, 32'd1);
        #1;
        reset = 1'b1;
        #1;
        check("midrun reset_flags", {29'b0, busy, done, div_zero}, 32'd0);
        check("midrun reset_hi", hi_out, 32'd0);
        check("midrun reset_lo", lo_out, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("midrun no_late_done", {30'b0, busy, done}, 32'd0);
        v = '{1'b1, 1'b0, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0, 34};
        do_op("after_reset", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
